// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute control sequencer: steps one instruction at a time and
// stalls on memory, data-bus and IO handshakes. It also counts retired instructions.
module cpu_sequencer #(
  parameter logic [31:0] INSTRET_RST = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic        ir_load,
  output logic        dec_en,
  output logic        exec_en,
  input  logic        halt_pending,
  input  logic        bus_pending,
  input  logic        io_pending,
  input  logic        bus_done,
  input  logic        io_done,
  output logic        pc_update,
  output logic        halted,
  output logic [31:0] instret,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    FETCH    = 3'd0,
    DECODE   = 3'd1,
    EXECUTE  = 3'd2,
    WAIT_BUS = 3'd3,
    WAIT_IO  = 3'd4,
    HALTED   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        io_q;
  logic        retire;
  logic [31:0] instret_q;

  // io_pending is captured in EXECUTE so a bus op can chain into IO later
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      instret_q <= INSTRET_RST;
      io_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire)
        instret_q <= instret_q + 32'd1;
      if (state_q == EXECUTE)
        io_q <= io_pending;
    end
  end

  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    mem_req   = 1'b0;
    ir_load   = 1'b0;
    dec_en    = 1'b0;
    exec_en   = 1'b0;
    pc_update = 1'b0;
    halted    = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_load = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        dec_en  = 1'b1;
        state_d = EXECUTE;
      end
      EXECUTE: begin
        exec_en   = 1'b1;
        pc_update = ~halt_pending;
        if (halt_pending) begin
          state_d = HALTED;
          retire  = 1'b1;
        end else if (bus_pending) begin
          state_d = WAIT_BUS;
        end else if (io_pending) begin
          state_d = WAIT_IO;
        end else begin
          state_d = FETCH;
          retire  = 1'b1;
        end
      end
      WAIT_BUS: begin
        if (bus_done) begin
          if (io_q) begin
            state_d = WAIT_IO;
          end else begin
            state_d = FETCH;
            retire  = 1'b1;
          end
        end
      end
      WAIT_IO: begin
        if (io_done) begin
          state_d = FETCH;
          retire  = 1'b1;
        end
      end
      HALTED: halted = 1'b1;
      default: state_d = FETCH;
    endcase
    // Reset forces every output low and discards any in-flight retirement
    if (rst) begin
      state_d   = FETCH;
      retire    = 1'b0;
      mem_req   = 1'b0;
      ir_load   = 1'b0;
      dec_en    = 1'b0;
      exec_en   = 1'b0;
      pc_update = 1'b0;
      halted    = 1'b0;
    end
  end

  assign state_dbg = rst ? 3'd0  : state_q;
  assign instret   = rst ? 32'd0 : instret_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed vector table, hand-written multi-cycle sequences
// and random traffic, all compared against a flag-based instruction-lifecycle model.
module tb_cpu_sequencer;

  localparam logic [31:0] PRE = 32'hFFFF_FFFD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, mem_ack, halt_pending, bus_pending, io_pending, bus_done, io_done;
  logic mem_req_a, ir_load_a, dec_en_a, exec_en_a, pc_update_a, halted_a;
  logic mem_req_b, ir_load_b, dec_en_b, exec_en_b, pc_update_b, halted_b;
  logic [31:0] instret_a, instret_b;
  logic [2:0]  state_dbg_a, state_dbg_b;

  cpu_sequencer dut_a (
    .clk(clk), .rst(rst), .mem_req(mem_req_a), .mem_ack(mem_ack), .ir_load(ir_load_a),
    .dec_en(dec_en_a), .exec_en(exec_en_a), .halt_pending(halt_pending),
    .bus_pending(bus_pending), .io_pending(io_pending), .bus_done(bus_done),
    .io_done(io_done), .pc_update(pc_update_a), .halted(halted_a),
    .instret(instret_a), .state_dbg(state_dbg_a)
  );

  // Second copy preloaded near the top of the counter range to exercise wrap
  cpu_sequencer #(.INSTRET_RST(PRE)) dut_b (
    .clk(clk), .rst(rst), .mem_req(mem_req_b), .mem_ack(mem_ack), .ir_load(ir_load_b),
    .dec_en(dec_en_b), .exec_en(exec_en_b), .halt_pending(halt_pending),
    .bus_pending(bus_pending), .io_pending(io_pending), .bus_done(bus_done),
    .io_done(io_done), .pc_update(pc_update_b), .halted(halted_b),
    .instret(instret_b), .state_dbg(state_dbg_b)
  );

  int total = 0;
  int bad   = 0;

  bit m_fetch = 1'b1, m_dec = 1'b0, m_exe = 1'b0, m_wbus = 1'b0, m_wio = 1'b0;
  bit m_halt = 1'b0, m_io_after_bus = 1'b0;
  logic [31:0] m_instret = 32'd0;

  typedef struct {
    logic r, a, h, b, i, bd, iod;
    logic [2:0]  st;
    logic [5:0]  outs;
    logic [31:0] ir;
  } vec_t;
  vec_t tbl[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] model_code();
    if (m_fetch) return 3'd0;
    if (m_dec)   return 3'd1;
    if (m_exe)   return 3'd2;
    if (m_wbus)  return 3'd3;
    if (m_wio)   return 3'd4;
    return 3'd5;
  endfunction

  // Expected {state, mem_req, ir_load, dec_en, exec_en, pc_update, halted}
  function automatic logic [8:0] model_outs();
    if (rst) return 9'd0;
    return {model_code(), m_fetch, m_fetch & mem_ack, m_dec, m_exe,
            m_exe & ~halt_pending, m_halt};
  endfunction

  task automatic applyStimulus(input logic r, a, h, b, i, bd, iod);
    logic [31:0] exp_ir;
    @(negedge clk);
    rst = r; mem_ack = a; halt_pending = h; bus_pending = b;
    io_pending = i; bus_done = bd; io_done = iod;
    #1;
    exp_ir = rst ? 32'd0 : m_instret;
    checkOutput("outs_a", 32'({state_dbg_a, mem_req_a, ir_load_a, dec_en_a, exec_en_a,
                               pc_update_a, halted_a}), 32'(model_outs()));
    checkOutput("instret_a", instret_a, exp_ir);
    checkOutput("outs_b", 32'({state_dbg_b, mem_req_b, ir_load_b, dec_en_b, exec_en_b,
                               pc_update_b, halted_b}), 32'(model_outs()));
    checkOutput("instret_b", instret_b, rst ? 32'd0 : m_instret + PRE);
  endtask

  task automatic retire_to_fetch();
    m_fetch   = 1'b1;
    m_instret = m_instret + 32'd1;
  endtask

  task automatic clockModel();
    @(posedge clk);
    if (rst) begin
      {m_dec, m_exe, m_wbus, m_wio, m_halt, m_io_after_bus} = '0;
      m_fetch   = 1'b1;
      m_instret = 32'd0;
    end else if (m_halt) begin
      m_halt = 1'b1;
    end else if (m_fetch) begin
      if (mem_ack) begin m_fetch = 1'b0; m_dec = 1'b1; end
    end else if (m_dec) begin
      m_dec = 1'b0; m_exe = 1'b1;
    end else if (m_exe) begin
      m_exe = 1'b0;
      if (halt_pending) begin
        m_halt = 1'b1; m_instret = m_instret + 32'd1;
      end else if (bus_pending) begin
        m_wbus = 1'b1; m_io_after_bus = io_pending;
      end else if (io_pending) begin
        m_wio = 1'b1;
      end else begin
        retire_to_fetch();
      end
    end else if (m_wbus) begin
      if (bus_done) begin
        m_wbus = 1'b0;
        if (m_io_after_bus) m_wio = 1'b1;
        else retire_to_fetch();
      end
    end else if (m_wio) begin
      if (io_done) begin m_wio = 1'b0; retire_to_fetch(); end
    end
  endtask

  task automatic step(input logic r, a, h, b, i, bd, iod);
    applyStimulus(r, a, h, b, i, bd, iod);
    clockModel();
  endtask

  task automatic add(input logic r, a, h, b, i, bd, iod, input logic [2:0] st,
                     input logic [5:0] outs, input logic [31:0] ir);
    vec_t v;
    v.r = r; v.a = a; v.h = h; v.b = b; v.i = i; v.bd = bd; v.iod = iod;
    v.st = st; v.outs = outs; v.ir = ir;
    tbl.push_back(v);
  endtask

  task automatic expect_reg(input string name, input logic [2:0] st, input logic [31:0] ir);
    #1;
    checkOutput({name, "_state"}, 32'(state_dbg_a), 32'(st));
    checkOutput({name, "_instret"}, instret_a, ir);
  endtask

  initial begin
    {rst, mem_ack, halt_pending, bus_pending, io_pending, bus_done, io_done} = 7'b1000000;

    //   r a h b i bd iod st  {req,ir,dec,exe,pc,hlt}  instret
    add(1,0,0,0,0,0,0, 3'd0, 6'b000000, 0);
    add(0,1,0,0,0,0,0, 3'd0, 6'b110000, 0);
    add(0,0,0,0,0,0,0, 3'd1, 6'b001000, 0);
    add(0,0,0,0,0,0,0, 3'd2, 6'b000110, 0);
    add(0,0,0,0,0,0,0, 3'd0, 6'b100000, 1);
    add(0,1,0,0,0,0,0, 3'd0, 6'b110000, 1);
    add(0,0,0,0,0,0,0, 3'd1, 6'b001000, 1);
    add(0,0,0,1,1,0,0, 3'd2, 6'b000110, 1);
    add(0,0,0,0,0,0,1, 3'd3, 6'b000000, 1);
    add(0,0,0,0,0,1,0, 3'd3, 6'b000000, 1);
    add(0,0,0,0,0,1,0, 3'd4, 6'b000000, 1);
    add(0,0,0,0,0,0,1, 3'd4, 6'b000000, 1);
    add(0,1,0,0,0,0,0, 3'd0, 6'b110000, 2);
    add(0,0,0,0,0,0,0, 3'd1, 6'b001000, 2);
    add(0,0,1,1,0,0,0, 3'd2, 6'b000100, 2);
    add(0,1,0,0,0,1,0, 3'd5, 6'b000001, 3);
    add(0,1,1,0,0,0,1, 3'd5, 6'b000001, 3);
    add(1,0,0,0,0,0,0, 3'd0, 6'b000000, 0);
    add(0,0,0,0,0,0,0, 3'd0, 6'b100000, 0);

    foreach (tbl[n]) begin
      applyStimulus(tbl[n].r, tbl[n].a, tbl[n].h, tbl[n].b, tbl[n].i, tbl[n].bd, tbl[n].iod);
      checkOutput($sformatf("tbl%0d_outs", n),
                  32'({state_dbg_a, mem_req_a, ir_load_a, dec_en_a, exec_en_a, pc_update_a, halted_a}),
                  32'({tbl[n].st, tbl[n].outs}));
      checkOutput($sformatf("tbl%0d_instret", n), instret_a, tbl[n].ir);
      if (n == 14) checkOutput("pre_wrap", instret_b, 32'hFFFF_FFFF);
      if (n == 15) checkOutput("wrap", instret_b, 32'h0000_0000);
      clockModel();
    end

    // Bus wait held for five cycles, retiring only on bus_done
    step(0,1,0,0,0,0,0);
    step(0,0,0,0,0,0,0);
    step(0,0,0,1,0,0,0);
    for (int k = 0; k < 5; k++) begin
      expect_reg("buswait", 3'd3, 32'd0);
      step(0,0,0,0,0, (k == 4) ? 1'b1 : 1'b0, 0);
    end
    expect_reg("busdone", 3'd0, 32'd1);

    // Reset in the middle of an IO wait with seven instructions retired
    step(1,0,0,0,0,0,0);
    for (int k = 0; k < 7; k++) begin
      step(0,1,0,0,0,0,0);
      step(0,0,0,0,0,0,0);
      step(0,0,0,0,0,0,0);
    end
    expect_reg("seven", 3'd0, 32'd7);
    step(0,1,0,0,0,0,0);
    step(0,0,0,0,0,0,0);
    step(0,0,0,0,1,0,0);
    step(0,0,0,0,0,0,0);
    expect_reg("iowait", 3'd4, 32'd7);
    step(1,0,0,0,0,0,1);
    expect_reg("inrst", 3'd0, 32'd0);
    checkOutput("inrst_memreq", 32'(mem_req_a), 32'd0);
    applyStimulus(0,0,0,0,0,0,1);
    checkOutput("postrst_memreq", 32'(mem_req_a), 32'd1);
    checkOutput("postrst_instret", instret_a, 32'd0);
    clockModel();

    // Random traffic against the model
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(99) < 2,  $urandom_range(99) < 40, $urandom_range(99) < 8,
           $urandom_range(99) < 40, $urandom_range(99) < 40,
           $urandom_range(99) < 30, $urandom_range(99) < 30);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have: clk  input  1  single clock; all state updates on posedge clk.
REQ-002 SHALL have: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have: mem_req  output  1  instruction-fetch request to the bus; held until acknowledged.
REQ-004 SHALL have: mem_ack  input  1  one-cycle pulse: fetched word valid this cycle.
REQ-005 SHALL have: ir_load  output  1  one-cycle strobe: load fetched word into instruction register.
REQ-006 SHALL have: dec_en  output  1  one-cycle enable to the instruction decoder.
REQ-007 SHALL have: exec_en  output  1  one-cycle strobe: ALU/CU/IO/bus units execute decoded instruction.
REQ-008 SHALL have: halt_pending  input  1  decoded CU op is a halt; valid from EXECUTE onward.
REQ-009 SHALL have: bus_pending  input  1  decoded bus op is not BUS_NOP.
REQ-010 SHALL have: io_pending  input  1  decoded IO op is not IO_NOP.
REQ-011 SHALL have: bus_done  input  1  one-cycle pulse: data bus transfer complete.
REQ-012 SHALL have: io_done  input  1  one-cycle pulse: IO transfer complete.
REQ-013 SHALL have: pc_update  output  1  one-cycle strobe: PC takes next/jump address.
REQ-014 SHALL have: halted  output  1  level; machine stopped.
REQ-015 SHALL have: instret  output  32  retired-instruction counter.
REQ-016 SHALL have: state_dbg  output  3  current state encoding, for observation only.

Function
REQ-017 States SHALL be FETCH=0, DECODE=1, EXECUTE=2, WAIT_BUS=3, WAIT_IO=4, HALTED=5; codes 6-7 SHALL transition to FETCH.
REQ-018 FETCH: mem_req=1; on mem_ack, ir_load=1 in the same cycle, next=DECODE; otherwise remain.
REQ-019 DECODE: dec_en=1 for exactly one cycle; next=EXECUTE unconditionally.
REQ-020 EXECUTE: exec_en=1 for exactly one cycle; transition priority: halt_pending -> HALTED; else bus_pending -> WAIT_BUS; else io_pending -> WAIT_IO; else FETCH.
REQ-021 pc_update SHALL pulse in EXECUTE unless halt_pending=1.
REQ-022 WAIT_BUS: hold until bus_done; then WAIT_IO if io_pending (latched in EXECUTE) else FETCH.
REQ-023 WAIT_IO: hold until io_done; then FETCH.
REQ-024 bus_pending/io_pending SHALL be latched at EXECUTE; changes afterwards SHALL be ignored.
REQ-025 mem_ack outside FETCH, bus_done outside WAIT_BUS, io_done outside WAIT_IO SHALL be ignored.
REQ-026 HALTED: halted=1, all strobes 0, all inputs ignored; exit only via rst.
REQ-027 instret SHALL increment by 1 on the cycle the instruction retires: EXECUTE->FETCH, WAIT_BUS->FETCH, WAIT_IO->FETCH, or EXECUTE->HALTED.
REQ-028 instret SHALL wrap 0xFFFF_FFFF -> 0x0000_0000 with no flag.
REQ-029 Minimum latency, no-wait instruction with mem_ack in first FETCH cycle: 3 cycles (FETCH, DECODE, EXECUTE).
REQ-030 At most one of ir_load, dec_en, exec_en SHALL be high in any cycle.

Reset
REQ-031 While rst=1: state<=FETCH, instret<=0, latched pending flags<=0; all outputs SHALL be 0, including mem_req and halted.
REQ-032 rst asserted in any state, including mid-WAIT or HALTED, SHALL abort the instruction without retiring it.
REQ-033 First cycle after rst deasserts SHALL have mem_req=1.

Verification
REQ-034 Reset, mem_ack on first FETCH cycle, all pending=0 -> ir_load at t0, dec_en t1, exec_en+pc_update t2, mem_req t3, instret=1.
REQ-035 bus_pending=1 at EXECUTE, bus_done after 5 cycles -> state=3 for 5 cycles, then FETCH; instret increments only on bus_done cycle.
REQ-036 bus_pending=1 and io_pending=1 -> WAIT_BUS until bus_done, then WAIT_IO until io_done, then FETCH; exactly one retirement.
REQ-037 halt_pending=1 at EXECUTE -> no pc_update, halted=1 next cycle, instret+1; later mem_ack/bus_done pulses leave halted=1 and strobes=0.
REQ-038 rst pulse during WAIT_IO with instret=7 -> instret=0, state=FETCH, mem_req=1 first cycle after rst.
REQ-039 Force instret to 0xFFFF_FFFF via 2^32-1 retired instructions or preload hook -> next retirement gives 0x0000_0000.
